ex_operand_forward_stage: RTL and testbench
===========================================

// Module: ex_operand_forward_stage
// PURPOSE
//  ID/EX boundary of the RV32IM pipeline. Registers decoded operands into EX.
//  Resolves each EX operand from three sources, using the registered MEM/WB match flags
//  produced by the ALU hazard unit: regfile value, MEM-stage result or WB-stage result.
//  Detects load-use hazards and enforces a one-cycle stall plus bubble.
//  Keeps a saturating stall counter for performance monitoring.
// PARAMETERS
//  XLEN      32  operand/data width
//  RADDR_W    5  register address width
//  CNT_W     16  stall counter width
// PORTS
//  CLK            in   1        pipeline clock
//  RESET          in   1        synchronous, active-high reset
//  ID_VALID       in   1        decode holds a real instruction
//  ID_SREG1/2     in   RADDR_W  source register addresses in ID
//  ID_USES_RS1/2  in   1        instruction actually reads rs1/rs2
//  ID_DATA1/2     in   XLEN     register-file read data
//  ID_RD          in   RADDR_W  destination register in ID
//  ID_IS_LOAD     in   1        ID instruction is a load
//  FLUSH          in   1        branch/jump redirect; kill ID->EX transfer
//  MEM_TO_SREG1/2 in   1        hazard-unit flag: EX rs matches MEM-stage rd
//  WB_TO_SREG1/2  in   1        hazard-unit flag: EX rs matches WB-stage rd
//  MEM_VALID      in   1        MEM stage holds a valid rd-writing instruction
//  WB_VALID       in   1        WB stage holds a valid rd-writing instruction
//  MEM_FWD_DATA   in   XLEN     ALU result in MEM stage
//  WB_FWD_DATA    in   XLEN     write-back data
//  STALL          out  1        hold PC and IF/ID this cycle (combinational)
//  EX_VALID       out  1        EX holds a real instruction
//  EX_OP1/2       out  XLEN     forwarded operands to the ALU (combinational)
//  EX_RD          out  RADDR_W  registered destination
//  EX_IS_LOAD     out  1        registered load flag
//  STALL_COUNT    out  CNT_W    saturating count of load-use stall cycles
// BEHAVIOUR
//  - Reset (sync, RESET=1 at posedge): EX_VALID=0; EX_RD=0; EX_IS_LOAD=0.
//    Registered SREG/DATA are cleared to 0, so EX_OP1/2=0. STALL_COUNT=0; state=RUN.
//  - Hazard HZ = EX_VALID & EX_IS_LOAD & (EX_RD!=0) & ID_VALID &
//    ((ID_USES_RS1 & ID_SREG1==EX_RD) | (ID_USES_RS2 & ID_SREG2==EX_RD)).
//  - FSM, two states:
//    RUN: STALL=HZ & ~FLUSH. If STALL, go to BUBBLE.
//    BUBBLE: STALL=0 always; return to RUN unconditionally (never two stall cycles per load).
//  - Posedge update, in priority order:
//    1. RESET.
//    2. FLUSH or STALL: EX_VALID<=0, EX_IS_LOAD<=0, EX_RD<=0; other fields don't-care.
//    3. Otherwise: load all ID_* fields; EX_VALID<=ID_VALID.
//  - Operand select for opN, combinational, zero added latency:
//    MEM_TO_SREGn & MEM_VALID & EX_SREGn!=0 -> MEM_FWD_DATA
//    else WB_TO_SREGn & WB_VALID & EX_SREGn!=0 -> WB_FWD_DATA
//    else registered ID_DATAn.
//    MEM has priority over WB (younger producer wins). x0 is never forwarded.
//  - After the load-use bubble, the load sits in WB; its data reaches EX via the WB path.
//  - STALL_COUNT increments on each cycle with STALL=1 and saturates at all-ones.
//    FLUSH suppresses both the stall and the increment.
//  - FLUSH coincident with HZ: no stall, bubble inserted, state stays RUN.
//  - RESET mid-stall: BUBBLE abandoned; state=RUN next cycle.
//  - Same-cycle regfile write/read is the regfile's concern, not this block's.
// STRUCTURE
//  - Shared pipeline package: XLEN, RADDR_W, FSM state encoding (RUN=1'b0, BUBBLE=1'b1),
//    ID/EX field widths.
//  - One natural sub-module: operand_fwd_mux (3:1 priority mux with x0 guard),
//    instantiated twice. Stall FSM, ID/EX register and counter stay in this module.
// TESTING
//  1. RESET=1 for 2 cycles -> EX_VALID=0, EX_OP1=EX_OP2=0, STALL=0, STALL_COUNT=0.
//  2. add x5 then sub x6,x5,x1: MEM_TO_SREG1=1, MEM_VALID=1, MEM_FWD_DATA=0x000000AA
//     -> EX_OP1=0x000000AA; EX_OP2=ID_DATA2.
//  3. MEM and WB flags both set, MEM=0x11111111, WB=0x22222222 -> EX_OP1=0x11111111.
//     Drop MEM_VALID -> EX_OP1=0x22222222.
//  4. EX_SREG1=0 with MEM_TO_SREG1=1 and MEM_FWD_DATA=0xDEADBEEF -> EX_OP1=0 (regfile value).
//  5. lw x5 followed by add x7,x5,x5 -> STALL=1 for exactly one cycle; next EX_VALID=0;
//     STALL_COUNT 0->1; add then enters EX with WB_FWD_DATA on both operands.
//  6. Load-use with FLUSH=1 in the same cycle -> STALL=0, EX_VALID=0 next cycle,
//     STALL_COUNT unchanged. Preload the counter at all-ones and stall -> stays all-ones.

Source files
------------

// File: rtl/ex_operand_forward_stage_pkg.sv
// Shared ID/EX pipeline definitions: widths, stall FSM encoding, ID/EX payload.
package ex_operand_forward_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CNT_W   = 16;

    // Stall FSM encoding
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

    // Fields carried from ID into EX
    typedef struct packed {
        logic               valid;
        logic               is_load;
        logic [RADDR_W-1:0] rd;
        logic [RADDR_W-1:0] sreg1;
        logic [RADDR_W-1:0] sreg2;
        logic [XLEN-1:0]    data1;
        logic [XLEN-1:0]    data2;
    } id_ex_t;

    // True when a source register is actually read and equals the given rd
    function automatic logic src_hits_rd(
        input logic               uses,
        input logic [RADDR_W-1:0] sreg,
        input logic [RADDR_W-1:0] rd
    );
        return uses && (sreg == rd);
    endfunction

endpackage

// File: rtl/ex_operand_forward_stage_operand_fwd_mux.sv
// 3:1 priority operand mux: MEM result, then WB result, then regfile value.
// x0 is never forwarded.
module operand_fwd_mux
    import ex_operand_forward_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] i_sreg,
    input  logic               i_mem_match,
    input  logic               i_mem_valid,
    input  logic [XLEN-1:0]    i_mem_data,
    input  logic               i_wb_match,
    input  logic               i_wb_valid,
    input  logic [XLEN-1:0]    i_wb_data,
    input  logic [XLEN-1:0]    i_reg_data,
    output logic [XLEN-1:0]    o_op
);

    logic w_nonzero;

    // Younger producer (MEM) wins over WB; regfile value otherwise
    always_comb begin
        w_nonzero = (i_sreg != '0);
        o_op      = i_reg_data;
        if (i_mem_match && i_mem_valid && w_nonzero) begin
            o_op = i_mem_data;
        end else if (i_wb_match && i_wb_valid && w_nonzero) begin
            o_op = i_wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_forward_stage.sv
// ID/EX pipeline boundary: operand registration, forwarding, load-use stall
// with a single bubble, and a saturating stall-cycle counter.
module ex_operand_forward_stage
    import ex_operand_forward_stage_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = CNT_W
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_id_valid,
    input  logic [RADDR_W-1:0]     i_id_sreg1,
    input  logic [RADDR_W-1:0]     i_id_sreg2,
    input  logic                   i_id_uses_rs1,
    input  logic                   i_id_uses_rs2,
    input  logic [XLEN-1:0]        i_id_data1,
    input  logic [XLEN-1:0]        i_id_data2,
    input  logic [RADDR_W-1:0]     i_id_rd,
    input  logic                   i_id_is_load,
    input  logic                   i_flush,
    input  logic                   i_mem_to_sreg1,
    input  logic                   i_mem_to_sreg2,
    input  logic                   i_wb_to_sreg1,
    input  logic                   i_wb_to_sreg2,
    input  logic                   i_mem_valid,
    input  logic                   i_wb_valid,
    input  logic [XLEN-1:0]        i_mem_fwd_data,
    input  logic [XLEN-1:0]        i_wb_fwd_data,
    output logic                   o_stall,
    output logic                   o_ex_valid,
    output logic [XLEN-1:0]        o_ex_op1,
    output logic [XLEN-1:0]        o_ex_op2,
    output logic [RADDR_W-1:0]     o_ex_rd,
    output logic                   o_ex_is_load,
    output logic [STALL_CNT_W-1:0] o_stall_count
);

    id_ex_t                 r_id_ex;
    id_ex_t                 w_id_in;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_hz;
    logic                   w_stall;
    logic [STALL_CNT_W-1:0] r_stall_count;

    // Pack the decode-stage fields into the ID/EX payload
    always_comb begin
        w_id_in         = '0;
        w_id_in.valid   = i_id_valid;
        w_id_in.is_load = i_id_is_load;
        w_id_in.rd      = i_id_rd;
        w_id_in.sreg1   = i_id_sreg1;
        w_id_in.sreg2   = i_id_sreg2;
        w_id_in.data1   = i_id_data1;
        w_id_in.data2   = i_id_data2;
    end

    // Load-use hazard: load in EX writes a register the ID instruction reads
    always_comb begin
        w_hz = r_id_ex.valid && r_id_ex.is_load && (r_id_ex.rd != '0) && i_id_valid &&
               (src_hits_rd(i_id_uses_rs1, i_id_sreg1, r_id_ex.rd) ||
                src_hits_rd(i_id_uses_rs2, i_id_sreg2, r_id_ex.rd));
    end

    // Stall FSM next-state/output: at most one stall cycle per load
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = w_hz && !i_flush;
                if (w_stall) begin
                    w_state_nxt = ST_BUBBLE;
                end
            end
            ST_BUBBLE: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Stall FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ID/EX register: flush or stall injects a bubble, otherwise capture ID
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_id_ex <= '0;
        end else if (i_flush || w_stall) begin
            r_id_ex.valid   <= 1'b0;
            r_id_ex.is_load <= 1'b0;
            r_id_ex.rd      <= '0;
        end else begin
            r_id_ex <= w_id_in;
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + STALL_CNT_W'(1);
        end
    end

    operand_fwd_mux u_fwd_op1 (
        .i_sreg      (r_id_ex.sreg1),
        .i_mem_match (i_mem_to_sreg1),
        .i_mem_valid (i_mem_valid),
        .i_mem_data  (i_mem_fwd_data),
        .i_wb_match  (i_wb_to_sreg1),
        .i_wb_valid  (i_wb_valid),
        .i_wb_data   (i_wb_fwd_data),
        .i_reg_data  (r_id_ex.data1),
        .o_op        (o_ex_op1)
    );

    operand_fwd_mux u_fwd_op2 (
        .i_sreg      (r_id_ex.sreg2),
        .i_mem_match (i_mem_to_sreg2),
        .i_mem_valid (i_mem_valid),
        .i_mem_data  (i_mem_fwd_data),
        .i_wb_match  (i_wb_to_sreg2),
        .i_wb_valid  (i_wb_valid),
        .i_wb_data   (i_wb_fwd_data),
        .i_reg_data  (r_id_ex.data2),
        .o_op        (o_ex_op2)
    );

    assign o_stall       = w_stall;
    assign o_ex_valid    = r_id_ex.valid;
    assign o_ex_rd       = r_id_ex.rd;
    assign o_ex_is_load  = r_id_ex.is_load;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_ex_operand_forward_stage.sv
// Directed bench for the ID/EX forwarding stage: vector table for operand
// selection plus hand sequences for load-use stall, flush and saturation.
module tb_ex_operand_forward_stage;
    import ex_operand_forward_stage_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               id_valid, id_uses_rs1, id_uses_rs2, id_is_load, flush;
    logic [RADDR_W-1:0] id_sreg1, id_sreg2, id_rd;
    logic [XLEN-1:0]    id_data1, id_data2, mem_fwd_data, wb_fwd_data;
    logic               mem_to_sreg1, mem_to_sreg2, wb_to_sreg1, wb_to_sreg2;
    logic               mem_valid, wb_valid;

    logic               stall, ex_valid, ex_is_load;
    logic [XLEN-1:0]    ex_op1, ex_op2;
    logic [RADDR_W-1:0] ex_rd;
    logic [CNT_W-1:0]   stall_count;

    logic               s_stall, s_ex_valid, s_ex_is_load;
    logic [XLEN-1:0]    s_ex_op1, s_ex_op2;
    logic [RADDR_W-1:0] s_ex_rd;
    logic [2:0]         s_stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_operand_forward_stage dut (
        .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid),
        .i_id_sreg1(id_sreg1), .i_id_sreg2(id_sreg2),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_id_data1(id_data1), .i_id_data2(id_data2), .i_id_rd(id_rd),
        .i_id_is_load(id_is_load), .i_flush(flush),
        .i_mem_to_sreg1(mem_to_sreg1), .i_mem_to_sreg2(mem_to_sreg2),
        .i_wb_to_sreg1(wb_to_sreg1), .i_wb_to_sreg2(wb_to_sreg2),
        .i_mem_valid(mem_valid), .i_wb_valid(wb_valid),
        .i_mem_fwd_data(mem_fwd_data), .i_wb_fwd_data(wb_fwd_data),
        .o_stall(stall), .o_ex_valid(ex_valid), .o_ex_op1(ex_op1),
        .o_ex_op2(ex_op2), .o_ex_rd(ex_rd), .o_ex_is_load(ex_is_load),
        .o_stall_count(stall_count)
    );

    // Narrow-counter copy so saturation is reachable in a few cycles
    ex_operand_forward_stage #(.STALL_CNT_W(3)) dut_sat (
        .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid),
        .i_id_sreg1(id_sreg1), .i_id_sreg2(id_sreg2),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_id_data1(id_data1), .i_id_data2(id_data2), .i_id_rd(id_rd),
        .i_id_is_load(id_is_load), .i_flush(flush),
        .i_mem_to_sreg1(mem_to_sreg1), .i_mem_to_sreg2(mem_to_sreg2),
        .i_wb_to_sreg1(wb_to_sreg1), .i_wb_to_sreg2(wb_to_sreg2),
        .i_mem_valid(mem_valid), .i_wb_valid(wb_valid),
        .i_mem_fwd_data(mem_fwd_data), .i_wb_fwd_data(wb_fwd_data),
        .o_stall(s_stall), .o_ex_valid(s_ex_valid), .o_ex_op1(s_ex_op1),
        .o_ex_op2(s_ex_op2), .o_ex_rd(s_ex_rd), .o_ex_is_load(s_ex_is_load),
        .o_stall_count(s_stall_count)
    );

    typedef struct {
        string              name;
        logic               valid;
        logic [RADDR_W-1:0] s1, s2, rd;
        logic [XLEN-1:0]    d1, d2;
        logic               m1, m2, w1, w2, mv, wv;
        logic [XLEN-1:0]    md, wd;
        logic [XLEN-1:0]    e1, e2;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(
        input string name, input logic valid,
        input logic [RADDR_W-1:0] s1, input logic [RADDR_W-1:0] s2,
        input logic [RADDR_W-1:0] rd,
        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
        input logic m1, input logic m2, input logic w1, input logic w2,
        input logic mv, input logic wv,
        input logic [XLEN-1:0] md, input logic [XLEN-1:0] wd,
        input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2
    );
        vec_t v;
        v.name = name; v.valid = valid; v.s1 = s1; v.s2 = s2; v.rd = rd;
        v.d1 = d1; v.d2 = d2; v.m1 = m1; v.m2 = m2; v.w1 = w1; v.w2 = w2;
        v.mv = mv; v.wv = wv; v.md = md; v.wd = wd; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(
        input logic v, input logic [RADDR_W-1:0] s1, input logic [RADDR_W-1:0] s2,
        input logic u1, input logic u2, input logic [XLEN-1:0] d1,
        input logic [XLEN-1:0] d2, input logic [RADDR_W-1:0] rd, input logic ld
    );
        id_valid = v; id_sreg1 = s1; id_sreg2 = s2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_data1 = d1; id_data2 = d2; id_rd = rd; id_is_load = ld;
    endtask

    task automatic clr_fwd();
        mem_to_sreg1 = 1'b0; mem_to_sreg2 = 1'b0; wb_to_sreg1 = 1'b0; wb_to_sreg2 = 1'b0;
        mem_valid = 1'b0; wb_valid = 1'b0; mem_fwd_data = '0; wb_fwd_data = '0;
    endtask

    initial begin
        vecs[0] = mk("sub_mem_op1", 1'b1, 5'd5, 5'd1, 5'd6, 32'h100, 32'h7,
                     1, 0, 0, 0, 1, 0, 32'h000000AA, 32'h0, 32'h000000AA, 32'h7);
        vecs[1] = mk("mem_over_wb", 1'b1, 5'd3, 5'd4, 5'd8, 32'h1, 32'h2,
                     1, 0, 1, 0, 1, 1, 32'h11111111, 32'h22222222, 32'h11111111, 32'h2);
        vecs[2] = mk("wb_when_mem_invalid", 1'b1, 5'd3, 5'd4, 5'd8, 32'h1, 32'h2,
                     1, 0, 1, 0, 0, 1, 32'h11111111, 32'h22222222, 32'h22222222, 32'h2);
        vecs[3] = mk("x0_no_fwd", 1'b1, 5'd0, 5'd9, 5'd3, 32'h0, 32'h99,
                     1, 0, 0, 1, 1, 0, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h99);
        vecs[4] = mk("wb_op2", 1'b1, 5'd2, 5'd8, 5'd10, 32'hA5A5A5A5, 32'h3,
                     0, 0, 0, 1, 0, 1, 32'h0, 32'hCAFEF00D, 32'hA5A5A5A5, 32'hCAFEF00D);
        vecs[5] = mk("no_fwd", 1'b1, 5'd12, 5'd13, 5'd14, 32'h0000BEEF, 32'hFFFF0000,
                     0, 0, 0, 0, 1, 1, 32'h77777777, 32'h88888888, 32'h0000BEEF, 32'hFFFF0000);
        vecs[6] = mk("mem_op2_over_wb", 1'b1, 5'd1, 5'd31, 5'd31, 32'h4, 32'h5,
                     0, 1, 0, 1, 1, 1, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h4, 32'h0F0F0F0F);
        vecs[7] = mk("id_invalid", 1'b0, 5'd7, 5'd8, 5'd0, 32'h6, 32'h9,
                     0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h6, 32'h9);

        // Reset for two cycles with junk on the ID side
        reset = 1'b1; flush = 1'b0;
        clr_fwd();
        set_id(1, 5'd5, 5'd6, 1, 1, 32'hAB, 32'hCD, 5'd7, 1);
        tick(); tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_op1", ex_op1, 32'h0);
        chk("rst_op2", ex_op2, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_count", 32'(stall_count), 32'h0);
        chk("rst_ex_rd", 32'(ex_rd), 32'h0);
        chk("rst_ex_is_load", 32'(ex_is_load), 32'h0);
        reset = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Operand-select table
        for (int i = 0; i < 8; i++) begin
            clr_fwd();
            set_id(vecs[i].valid, vecs[i].s1, vecs[i].s2, 1, 1,
                   vecs[i].d1, vecs[i].d2, vecs[i].rd, 0);
            tick();
            mem_to_sreg1 = vecs[i].m1; mem_to_sreg2 = vecs[i].m2;
            wb_to_sreg1  = vecs[i].w1; wb_to_sreg2  = vecs[i].w2;
            mem_valid    = vecs[i].mv; wb_valid     = vecs[i].wv;
            mem_fwd_data = vecs[i].md; wb_fwd_data  = vecs[i].wd;
            #1;
            chk({vecs[i].name, "_op1"}, ex_op1, vecs[i].e1);
            chk({vecs[i].name, "_op2"}, ex_op2, vecs[i].e2);
            chk({vecs[i].name, "_valid"}, 32'(ex_valid), 32'(vecs[i].valid));
            chk({vecs[i].name, "_rd"}, 32'(ex_rd), 32'(vecs[i].rd));
            chk({vecs[i].name, "_stall"}, 32'(stall), 32'h0);
        end

        // lw x5 then add x7,x5,x5: one stall, one bubble, then WB forward
        clr_fwd();
        set_id(1, 5'd2, 5'd0, 1, 0, 32'h0, 32'h0, 5'd5, 1);
        tick();
        chk("lu_load_in_ex", 32'(ex_is_load), 32'h1);
        set_id(1, 5'd5, 5'd5, 1, 1, 32'h1, 32'h2, 5'd7, 0);
        #1;
        chk("lu_stall", 32'(stall), 32'h1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
        chk("lu_bubble_stall", 32'(stall), 32'h0);
        chk("lu_count", 32'(stall_count), 32'h1);
        chk("lu_count_sat_inst", 32'(s_stall_count), 32'h1);
        tick();
        wb_to_sreg1 = 1'b1; wb_to_sreg2 = 1'b1; wb_valid = 1'b1;
        wb_fwd_data = 32'h55AA55AA;
        #1;
        chk("lu_add_valid", 32'(ex_valid), 32'h1);
        chk("lu_add_rd", 32'(ex_rd), 32'h7);
        chk("lu_add_op1", ex_op1, 32'h55AA55AA);
        chk("lu_add_op2", ex_op2, 32'h55AA55AA);
        chk("lu_add_stall", 32'(stall), 32'h0);
        chk("lu_add_count", 32'(stall_count), 32'h1);

        // Load-use coincident with flush: no stall, bubble, count unchanged
        clr_fwd();
        set_id(1, 5'd2, 5'd0, 1, 0, 32'h0, 32'h0, 5'd5, 1);
        tick();
        set_id(1, 5'd5, 5'd5, 1, 1, 32'h1, 32'h2, 5'd7, 0);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_ex_valid", 32'(ex_valid), 32'h0);
        chk("fl_count", 32'(stall_count), 32'h1);
        chk("fl_stall_after", 32'(stall), 32'h0);

        // Back-to-back lw x5,0(x5): ten stalls, narrow counter saturates
        set_id(1, 5'd5, 5'd0, 1, 0, 32'h0, 32'h0, 5'd5, 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("sat_stall_%0d", k), 32'(stall), 32'h1);
            tick();
            chk($sformatf("sat_bubble_%0d", k), 32'(stall), 32'h0);
            tick();
        end
        chk("sat_count_wide", 32'(stall_count), 32'd11);
        chk("sat_count_narrow", 32'(s_stall_count), 32'd7);
        chk("sat_narrow_stall", 32'(s_stall), 32'h1);

        // Reset while stalling abandons the bubble
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_ex_valid", 32'(ex_valid), 32'h0);
        chk("rs_count", 32'(stall_count), 32'h0);
        chk("rs_count_narrow", 32'(s_stall_count), 32'h0);
        tick();
        chk("rs_reload_valid", 32'(ex_valid), 32'h1);
        chk("rs_restall", 32'(stall), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
